// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use stalls, taken-branch flushes,
// multi-cycle EX-op freeze, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MC_LATENCY = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_RegisterRt,
  input  logic [4:0]       if_id_RegisterRs,
  input  logic [4:0]       if_id_RegisterRt,
  input  logic             branch_taken,
  input  logic             mc_start,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned CW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use;

  assign load_use = id_ex_MemRead && (id_ex_RegisterRt != 5'd0) &&
                    ((id_ex_RegisterRt == if_id_RegisterRs) ||
                     (id_ex_RegisterRt == if_id_RegisterRt));

  // Next-state and combinational hazard outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_done       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (mc_start) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_d         = CW'(MC_LATENCY - 2);
            state_d       = MC_WAIT;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          if (cnt_q != '0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_d         = cnt_q - CW'(1);
          end else begin
            // Result leaves EX; ID-stage hazards still apply this cycle.
            mc_done = 1'b1;
            state_d = RUN;
            if (load_use) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end else if (branch_taken) begin
              if_id_flush = 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  assign mc_busy   = !rst && (state_q == MC_WAIT);
  assign stall_cnt = rst ? '0 : stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl: latency-8 / 4-bit counter instance plus
// a latency-2 instance sharing the same stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mr;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       br, mc;

  logic       pw, ifw, fl, idw, bub, exb, busy, done;
  logic [3:0] cnt;
  logic       pw2, ifw2, fl2, idw2, bub2, exb2, busy2, done2;
  logic [15:0] cnt2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LATENCY(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .id_ex_MemRead(mr), .id_ex_RegisterRt(ex_rt),
    .if_id_RegisterRs(id_rs), .if_id_RegisterRt(id_rt), .branch_taken(br),
    .mc_start(mc), .pc_write(pw), .if_id_write(ifw), .if_id_flush(fl),
    .id_ex_write(idw), .id_ex_bubble(bub), .ex_mem_bubble(exb),
    .mc_busy(busy), .mc_done(done), .stall_cnt(cnt)
  );

  hazard_ctrl #(.MC_LATENCY(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .id_ex_MemRead(mr), .id_ex_RegisterRt(ex_rt),
    .if_id_RegisterRs(id_rs), .if_id_RegisterRt(id_rt), .branch_taken(br),
    .mc_start(mc), .pc_write(pw2), .if_id_write(ifw2), .if_id_flush(fl2),
    .id_ex_write(idw2), .id_ex_bubble(bub2), .ex_mem_bubble(exb2),
    .mc_busy(busy2), .mc_done(done2), .stall_cnt(cnt2)
  );

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       mc;
    logic [7:0] outs;   // pw,ifw,fl,idw,bub,exb,busy,done
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic r, input logic m, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] c, input logic bt,
                       input logic s);
    rst = r; mr = m; ex_rt = a; id_rs = b; id_rt = c; br = bt; mc = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    // rst mr ex_rt rs rt br mc | pw ifw fl idw bub exb busy done | cnt
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 8'b1101_0000, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b1101_0000, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 8'b0001_1000, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 8'b1101_0000, 4'd1};
    vecs[4]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b1101_0000, 4'd1};
    vecs[5]  = '{1'b0, 1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 8'b0001_1000, 4'd1};
    vecs[6]  = '{1'b0, 1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 8'b1111_0000, 4'd2};
    vecs[7]  = '{1'b0, 1'b1, 5'd9, 5'd1, 5'd2, 1'b0, 1'b0, 8'b1101_0000, 4'd2};
    vecs[8]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 8'b0000_0100, 4'd2};
    vecs[9]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'b1101_0000, 4'd0};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b1101_0000, 4'd0};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt,
            vecs[i].br, vecs[i].mc);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'({pw, ifw, fl, idw, bub, exb, busy, done}),
          32'(vecs[i].outs));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
      next_cycle();
    end

    // Two back-to-back multi-cycle ops with mc_start held, then release.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      int j;
      int exp_cnt;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (k < 16) ? 1'b1 : 1'b0);
      j = k % 8;
      exp_cnt = (k < 8) ? ((k < 7) ? k : 7) : ((k < 16) ? 7 + ((j < 7) ? j : 7) : 14);
      @(negedge clk);
      if (k < 16) begin
        chk($sformatf("mc_k%0d_pw", k),   32'(pw),   32'(j == 7));
        chk($sformatf("mc_k%0d_exb", k),  32'(exb),  32'(j != 7));
        chk($sformatf("mc_k%0d_busy", k), 32'(busy), 32'(j != 0));
        chk($sformatf("mc_k%0d_done", k), 32'(done), 32'(j == 7));
        chk($sformatf("l2_k%0d_done", k), 32'(done2), 32'(k % 2 == 1));
        chk($sformatf("l2_k%0d_pw", k),   32'(pw2),   32'(k % 2 == 1));
        chk($sformatf("l2_k%0d_cnt", k),  32'(cnt2),  32'((k + 1) / 2));
      end else begin
        chk($sformatf("mc_k%0d_idle", k), 32'({pw, ifw, idw, exb, busy, done}),
            32'(6'b111000));
      end
      chk($sformatf("mc_k%0d_cnt", k), 32'(cnt), 32'(exp_cnt));
      next_cycle();
    end

    // Reset during MC_WAIT aborts the op without mc_done.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive((k == 3) ? 1'b1 : 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (k <= 3) ? 1'b1 : 1'b0);
      @(negedge clk);
      if (k == 2) chk("abort_pre_cnt", 32'(cnt), 32'd2);
      if (k == 3) chk("abort_forced", 32'({pw, ifw, fl, idw, bub, exb, busy, done, cnt}),
                      32'(12'b1101_0000_0000));
      if (k == 4) chk("abort_after", 32'({pw, busy, cnt}), 32'(6'b100000));
      if (k >= 3) chk($sformatf("abort_k%0d_nodone", k), 32'(done), 32'd0);
      next_cycle();
    end

    // Saturation of the 4-bit stall counter under a held load-use.
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("sat_i%0d_cnt", i), 32'(cnt), 32'((i < 15) ? i : 15));
      chk($sformatf("sat_i%0d_pw", i), 32'(pw), 32'd0);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
